// File: rtl/fetch.sv
// Instruction-fetch stage: owns the fetch PC and tracks in-flight reads through a
// two-slot shadow pipeline so pc/bubble/exc line up with the memory's two-cycle read data.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        tlb_miss,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic [31:0] pc_out,
  output logic        bubble_out,
  output logic [7:0]  exc_out
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [7:0]  exc;
  } slot_t;

  typedef enum logic {RUN, FAULT} state_t;

  localparam logic [7:0] EXC_MISALIGN = 8'h84;
  localparam logic [7:0] EXC_TLB      = 8'h82;

  state_t      state, state_nxt;
  logic [31:0] pc;
  slot_t       slot1, slot2;
  logic [7:0]  cur_exc;
  logic        advance;

  // Misalignment wins over a TLB miss; the MMU result is meaningless for a bad address.
  always_comb begin
    cur_exc = 8'h00;
    if (pc[1:0] != 2'b00) cur_exc = EXC_MISALIGN;
    else if (tlb_miss)    cur_exc = EXC_TLB;
  end

  assign advance = !halt && !flush && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!halt && flush)
      state_nxt = RUN;
    else if (advance && state == RUN && cur_exc != 8'h00)
      state_nxt = FAULT;
  end

  always_comb begin
    mem_addr   = pc;
    mem_re     = (state == RUN) && (pc[1:0] == 2'b00) && !halt && !rst;
    pc_out     = slot2.pc;
    bubble_out = !slot2.valid;
    exc_out    = slot2.exc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      slot1 <= '0;
      slot2 <= '0;
    end else if (!halt) begin
      if (flush) begin
        pc          <= redirect_pc;
        slot1.valid <= 1'b0;
        slot2.valid <= 1'b0;
      end else if (!stall) begin
        slot2 <= slot1;
        if (state == RUN) begin
          // A faulting fetch is issued as a valid slot so decode raises the exception.
          slot1 <= '{valid: 1'b1, pc: pc, exc: cur_exc};
          if (cur_exc == 8'h00) pc <= pc + 32'd4;
        end else begin
          slot1 <= '{valid: 1'b0, pc: pc, exc: 8'h00};
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: reset, streaming, stall, redirects, faults, wrap, async reset.
module tb_fetch;
  logic        clk = 1'b0;
  logic        rst, halt, stall, flush, tlb_miss;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr, pc_out;
  logic        mem_re, bubble_out;
  logic [7:0]  exc_out;

  int vectors = 0;
  int miscompares = 0;

  fetch dut (
    .clk(clk), .rst(rst), .halt(halt), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .tlb_miss(tlb_miss),
    .mem_addr(mem_addr), .mem_re(mem_re), .pc_out(pc_out),
    .bubble_out(bubble_out), .exc_out(exc_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; stall = 1'b0; flush = 1'b0; tlb_miss = 1'b0; redirect_pc = '0;
    step(); step();
    rst = 1'b0; #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    flush = 1'b1; redirect_pc = target;
    step();
    flush = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; stall = 1'b0; flush = 1'b0; tlb_miss = 1'b0; redirect_pc = '0;
    step(); step();
    vectors++; if (mem_addr !== 32'h400) begin miscompares++; $display("FAIL reset_addr got %h exp %h", mem_addr, 32'h400); end
    vectors++; if (bubble_out !== 1'b1) begin miscompares++; $display("FAIL reset_bubble got %b exp 1", bubble_out); end
    vectors++; if (pc_out !== 32'h0) begin miscompares++; $display("FAIL reset_pc_out got %h exp 0", pc_out); end
    vectors++; if (exc_out !== 8'h0) begin miscompares++; $display("FAIL reset_exc got %h exp 0", exc_out); end
    vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("FAIL reset_re got %b exp 0", mem_re); end
    rst = 1'b0; #1;
    vectors++; if (mem_re !== 1'b1) begin miscompares++; $display("FAIL reset_release_re got %b exp 1", mem_re); end
  endtask

  task automatic test_free_run();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      vectors++; if (mem_addr !== 32'h400 + 32'(4*i)) begin miscompares++; $display("FAIL run_addr[%0d] got %h exp %h", i, mem_addr, 32'h400 + 32'(4*i)); end
      vectors++; if (bubble_out !== (i < 2)) begin miscompares++; $display("FAIL run_bubble[%0d] got %b exp %b", i, bubble_out, (i < 2)); end
      if (i >= 2) begin
        vectors++; if (pc_out !== 32'h400 + 32'(4*(i-2))) begin miscompares++; $display("FAIL run_pc_out[%0d] got %h exp %h", i, pc_out, 32'h400 + 32'(4*(i-2))); end
      end
      step();
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step(); step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (mem_addr !== 32'h40C) begin miscompares++; $display("FAIL stall_addr[%0d] got %h exp 0000040c", i, mem_addr); end
      vectors++; if (pc_out !== 32'h404 || bubble_out !== 1'b0) begin miscompares++; $display("FAIL stall_out[%0d] got %h/%b exp 00000404/0", i, pc_out, bubble_out); end
    end
    stall = 1'b0;
    step();
    vectors++; if (pc_out !== 32'h408 || bubble_out !== 1'b0) begin miscompares++; $display("FAIL stall_resume0 got %h/%b exp 00000408/0", pc_out, bubble_out); end
    step();
    vectors++; if (pc_out !== 32'h40C || mem_addr !== 32'h414) begin miscompares++; $display("FAIL stall_resume1 got %h/%h exp 0000040c/00000414", pc_out, mem_addr); end
  endtask

  task automatic test_flush();
    redirect(32'h2000);
    vectors++; if (bubble_out !== 1'b1 || mem_addr !== 32'h2000) begin miscompares++; $display("FAIL flush_n1 got %b/%h exp 1/00002000", bubble_out, mem_addr); end
    step();
    vectors++; if (bubble_out !== 1'b1) begin miscompares++; $display("FAIL flush_n2 got %b exp 1", bubble_out); end
    step();
    vectors++; if (bubble_out !== 1'b0 || pc_out !== 32'h2000) begin miscompares++; $display("FAIL flush_n3 got %b/%h exp 0/00002000", bubble_out, pc_out); end
    step();
    vectors++; if (bubble_out !== 1'b0 || pc_out !== 32'h2004) begin miscompares++; $display("FAIL flush_n4 got %b/%h exp 0/00002004", bubble_out, pc_out); end
  endtask

  task automatic test_misaligned();
    redirect(32'h2002);
    vectors++; if (mem_re !== 1'b0 || mem_addr !== 32'h2002) begin miscompares++; $display("FAIL mis_issue got %b/%h exp 0/00002002", mem_re, mem_addr); end
    step();
    vectors++; if (bubble_out !== 1'b1 || mem_addr !== 32'h2002) begin miscompares++; $display("FAIL mis_hold got %b/%h exp 1/00002002", bubble_out, mem_addr); end
    step();
    vectors++; if (exc_out !== 8'h84 || pc_out !== 32'h2002 || bubble_out !== 1'b0) begin miscompares++; $display("FAIL mis_exc got %h/%h/%b exp 84/00002002/0", exc_out, pc_out, bubble_out); end
    step();
    vectors++; if (bubble_out !== 1'b1 || exc_out !== 8'h0) begin miscompares++; $display("FAIL mis_after got %b/%h exp 1/00", bubble_out, exc_out); end
    step();
    vectors++; if (bubble_out !== 1'b1 || mem_addr !== 32'h2002 || mem_re !== 1'b0) begin miscompares++; $display("FAIL mis_stuck got %b/%h/%b exp 1/00002002/0", bubble_out, mem_addr, mem_re); end
    redirect(32'h3000);
    step(); step();
    vectors++; if (pc_out !== 32'h3000 || bubble_out !== 1'b0 || exc_out !== 8'h0) begin miscompares++; $display("FAIL mis_recover got %h/%b/%h exp 00003000/0/00", pc_out, bubble_out, exc_out); end
  endtask

  task automatic test_tlb_miss();
    redirect(32'h500);
    tlb_miss = 1'b1; #1;
    vectors++; if (mem_re !== 1'b1 || mem_addr !== 32'h500) begin miscompares++; $display("FAIL tlb_issue got %b/%h exp 1/00000500", mem_re, mem_addr); end
    step();
    tlb_miss = 1'b0; #1;
    vectors++; if (mem_addr !== 32'h500 || mem_re !== 1'b0) begin miscompares++; $display("FAIL tlb_hold got %h/%b exp 00000500/0", mem_addr, mem_re); end
    step();
    vectors++; if (exc_out !== 8'h82 || pc_out !== 32'h500 || bubble_out !== 1'b0) begin miscompares++; $display("FAIL tlb_exc got %h/%h/%b exp 82/00000500/0", exc_out, pc_out, bubble_out); end
    step(); step();
    vectors++; if (bubble_out !== 1'b1 || mem_addr !== 32'h500) begin miscompares++; $display("FAIL tlb_stuck got %b/%h exp 1/00000500", bubble_out, mem_addr); end
  endtask

  task automatic test_flush_stall_halt();
    stall = 1'b1;
    redirect(32'h600);
    stall = 1'b0; #1;
    vectors++; if (mem_addr !== 32'h600 || bubble_out !== 1'b1 || mem_re !== 1'b1) begin miscompares++; $display("FAIL fs_redirect got %h/%b/%b exp 00000600/1/1", mem_addr, bubble_out, mem_re); end
    step(); step();
    vectors++; if (pc_out !== 32'h600 || bubble_out !== 1'b0 || mem_addr !== 32'h608) begin miscompares++; $display("FAIL fs_word got %h/%b/%h exp 00000600/0/00000608", pc_out, bubble_out, mem_addr); end
    halt = 1'b1; flush = 1'b1; redirect_pc = 32'h700; #1;
    vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("FAIL fh_re got %b exp 0", mem_re); end
    step();
    vectors++; if (mem_addr !== 32'h608 || pc_out !== 32'h600 || bubble_out !== 1'b0) begin miscompares++; $display("FAIL fh_hold got %h/%h/%b exp 00000608/00000600/0", mem_addr, pc_out, bubble_out); end
    halt = 1'b0; flush = 1'b0;
    step();
    vectors++; if (pc_out !== 32'h604 || mem_addr !== 32'h60C) begin miscompares++; $display("FAIL fh_resume got %h/%h exp 00000604/0000060c", pc_out, mem_addr); end
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFF8);
    step(); step();
    vectors++; if (mem_addr !== 32'h0 || pc_out !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL wrap_addr got %h/%h exp 00000000/fffffff8", mem_addr, pc_out); end
    step(); step();
    vectors++; if (pc_out !== 32'h0 || bubble_out !== 1'b0 || exc_out !== 8'h0) begin miscompares++; $display("FAIL wrap_word got %h/%b/%h exp 00000000/0/00", pc_out, bubble_out, exc_out); end
  endtask

  task automatic test_async_rst();
    step(); step();
    vectors++; if (bubble_out !== 1'b0) begin miscompares++; $display("FAIL arst_pre got %b exp 0", bubble_out); end
    rst = 1'b1; #1;
    vectors++; if (bubble_out !== 1'b1 || pc_out !== 32'h0 || exc_out !== 8'h0) begin miscompares++; $display("FAIL arst_out got %b/%h/%h exp 1/00000000/00", bubble_out, pc_out, exc_out); end
    vectors++; if (mem_addr !== 32'h400 || mem_re !== 1'b0) begin miscompares++; $display("FAIL arst_addr got %h/%b exp 00000400/0", mem_addr, mem_re); end
    #2 rst = 1'b0;
    step(); step();
    vectors++; if (pc_out !== 32'h400 || bubble_out !== 1'b0) begin miscompares++; $display("FAIL arst_restart got %h/%b exp 00000400/0", pc_out, bubble_out); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_flush();
    test_misaligned();
    test_tlb_miss();
    test_flush_stall_halt();
    test_wrap();
    test_async_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the Dioptase pipeline, directly upstream of `decode`. It owns the architectural fetch PC and drives the instruction-memory address port. It tracks each issued fetch through a two-slot shadow pipeline matched to the memory's two-cycle read latency, so `pc_out`, `bubble_out` and `exc_out` arrive at `decode` in the same cycle as the matching `mem_out_0` word. It also handles redirects (branch/exception/rfe), stalls, halt, and fetch-side faults.

## Interface
- `RESET_PC`, 32'h0000_0400, PC loaded on reset.
- `clk`  in  1  pipeline clock, all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `halt`  in  1  freezes all state, including redirects.
- `stall`  in  1  hazard stall from downstream; holds all state.
- `flush`  in  1  redirect request; valid for one cycle.
- `redirect_pc`  in  32  new fetch PC when `flush`=1.
- `tlb_miss`  in  1  combinational MMU miss for the current `mem_addr`.
- `mem_addr`  out  32  instruction-memory address; always equals the PC register.
- `mem_re`  out  1  read enable to instruction memory.
- `pc_out`  out  32  PC of the word on `mem_out_0` this cycle; goes to `decode` `pc_in`.
- `bubble_out`  out  1  1 = `mem_out_0` this cycle is not a valid instruction.
- `exc_out`  out  8  fetch exception code for that word; goes to `decode` `exc_in`.

## Operation
- Registers:
  - `pc` (32).
  - slot1 and slot2, each holding {valid, pc[31:0], exc[7:0]}.
  - `state` ∈ {RUN, FAULT}.
- Outputs:
  - `mem_addr`=`pc`.
  - `mem_re` = (state==RUN) && pc[1:0]==0 && !halt && !rst.
  - `pc_out`=slot2.pc, `bubble_out`=!slot2.valid, `exc_out`=slot2.exc.
- Fetch classification of the current `pc` (evaluated only in RUN):
  - pc[1:0]≠0 → exc 8'h84 (misaligned). Takes priority; `tlb_miss` is ignored in this case.
  - otherwise `tlb_miss`=1 → exc 8'h82.
  - otherwise exc 8'h00.
- Per posedge, priority order:
  1. `rst` (async): pc←RESET_PC, both slots valid←0, pc←0, exc←0, state←RUN.
  2. `halt`: hold everything.
  3. `flush` (overrides `stall`):
     - pc←redirect_pc; slot1.valid←0; slot2.valid←0; state←RUN.
     - The words already in flight are discarded.
  4. `stall`: hold everything. `mem_addr` is re-presented unchanged.
  5. RUN, advance:
     - slot2←slot1.
     - slot1←{1, pc, exc}.
     - If exc≠0: state←FAULT and pc holds. Otherwise pc←pc+4.
  6. FAULT, advance:
     - slot2←slot1; slot1←{0, pc, 0}; pc holds.
     - Only a `flush` leaves FAULT.
- Faulting slots carry valid=1, so `bubble_out`=0 with exc≠0. `decode` then propagates the exception instead of dropping it.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0). No fault is raised on wrap.

## Timing
- Issue latency: an address issued in cycle n appears with its `pc_out` in cycle n+2, aligned with `mem_out_0`. It is sampled by `decode` at the end of cycle n+2.
- After reset deasserts:
  - first valid word (pc=RESET_PC) reaches `bubble_out`=0 on the 2nd advancing posedge;
  - `bubble_out`=1 before that.
- Flush in cycle n:
  - `bubble_out`=1 in cycles n+1 and n+2;
  - `redirect_pc` word appears in cycle n+3 if no stalls.
- Stall: slots do not advance, so no word is duplicated or lost. `decode` re-uses its own buffered instruction.
- Flush together with stall: the flush is taken.
- Flush together with halt: the flush is ignored.
- Fault: exactly one faulting slot is emitted. Bubbles follow until a flush.
- Throughput: one instruction per cycle in RUN with no stall.

## Test plan
- Reset, then 6 free-running cycles:
  - `mem_addr` = 0x400, 0x404, 0x408…;
  - `pc_out` 0x400 with `bubble_out`=0 appears exactly two advancing cycles after the issue of 0x400.
- Stall held 3 cycles mid-stream at pc=0x40C:
  - `mem_addr`, `pc_out` and `bubble_out` hold constant;
  - after release, the `pc_out` sequence continues 0x408, 0x40C with no gap or repeat.
- Flush with `redirect_pc`=0x2000 at cycle n:
  - two bubbles, then `pc_out`=0x2000 at n+3, then 0x2004.
- Flush to 0x2002:
  - `mem_re`=0;
  - `exc_out`=0x84 with `pc_out`=0x2002 and `bubble_out`=0 two cycles later;
  - bubbles thereafter;
  - a flush to 0x3000 resumes normal fetch.
- `tlb_miss`=1 while pc=0x500:
  - `exc_out`=0x82 with `pc_out`=0x500 two cycles later;
  - `mem_addr` stays 0x500 until a redirect.
- Flush and stall asserted together, then flush and halt asserted together:
  - the first redirects;
  - the second leaves all state unchanged.
- Async `rst` pulse mid-stream: outputs return to `bubble_out`=1, `pc_out`=0, `exc_out`=0, `mem_addr`=0x400 before the next clock edge.
